alu1_src_mux: RTL and testbench

- Selects the first ALU operand from either the rs1 register-file read data or the current program counter.
- Registers the result for the execute stage.
- Sits between decode/register-read and the ALU input 1 port.
- ALU input 2 has its own independent mux.

---
 rtl/alu1_src_mux_pkg.sv | 24 ++
 rtl/alu1_src_mux_en_reg.sv | 32 +++
 rtl/alu1_src_mux.sv | 40 ++++
 tb/tb_alu1_src_mux.sv | 133 +++++++++++++
 4 files changed

// File: rtl/alu1_src_mux_pkg.sv
// Shared ALU operand-select definitions used by the ALU1/ALU2 muxes and the decoder.
// Define ALU1_ZERO_SEL_EN to add the ALU1_ZERO (load zero) source and widen the select to 2 bits.
package alu1_src_mux_pkg;

  localparam int unsigned REG_LEN = 31;

`ifdef ALU1_ZERO_SEL_EN
  localparam int unsigned ALU1_SEL_W = 2;

  typedef enum logic [ALU1_SEL_W-1:0] {
    ALU1_RS   = 2'b00,
    ALU1_PC   = 2'b01,
    ALU1_ZERO = 2'b10
  } alu1_sel_e;
`else
  localparam int unsigned ALU1_SEL_W = 1;

  typedef enum logic [ALU1_SEL_W-1:0] {
    ALU1_RS = 1'b0,
    ALU1_PC = 1'b1
  } alu1_sel_e;
`endif

endpackage

// File: rtl/alu1_src_mux_en_reg.sv
// Generic width-parameterised register with synchronous active-high reset and capture enable.
module en_reg #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (en_i) begin
      q_d = d_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/alu1_src_mux.sv
// ALU operand-1 source select (rs1 / pc, plus zero under ALU1_ZERO_SEL_EN), registered for execute.
module alu1_src_mux
  import alu1_src_mux_pkg::*;
#(
  parameter int unsigned REG_LEN = alu1_src_mux_pkg::REG_LEN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [ALU1_SEL_W-1:0] alu1_sel,
  input  logic [REG_LEN:0]      rs1_d,
  input  logic [REG_LEN:0]      pc,
  output logic [REG_LEN:0]      alu_in1
);

  logic [REG_LEN:0] alu_in1_d;

  // Reserved encodings fall through to rs1_d.
  always_comb begin
    alu_in1_d = rs1_d;
    case (alu1_sel)
      ALU1_PC:   alu_in1_d = pc;
`ifdef ALU1_ZERO_SEL_EN
      ALU1_ZERO: alu_in1_d = '0;
`endif
      default:   alu_in1_d = rs1_d;
    endcase
  end

  en_reg #(
    .W (REG_LEN + 1)
  ) u_alu_in1_reg (
    .clk  (clk),
    .rst  (rst),
    .en_i (en),
    .d_i  (alu_in1_d),
    .q_o  (alu_in1)
  );

endmodule

// File: tb/tb_alu1_src_mux.sv
// Directed self-checking bench for alu1_src_mux; also exercises the ALU1_ZERO_SEL_EN build when defined.
module tb_alu1_src_mux;
  import alu1_src_mux_pkg::*;

  logic                  clk;
  logic                  rst;
  logic                  en;
  logic [ALU1_SEL_W-1:0] alu1_sel;
  logic [31:0]           rs1_d;
  logic [31:0]           pc;
  logic [31:0]           alu_in1;

  int total = 0;
  int bad   = 0;

  // Reference model: expected output register contents.
  logic [31:0] m_val;
  logic        m_valid = 1'b0;
  logic        done    = 1'b0;

  alu1_src_mux #(
    .REG_LEN (31)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .alu1_sel (alu1_sel),
    .rs1_d    (rs1_d),
    .pc       (pc),
    .alu_in1  (alu_in1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] pick(input int sel, input logic [31:0] a, input logic [31:0] p);
    if (sel == 1) return p;
    if (sel == 2) return 32'h0;
    return a;
  endfunction

  always @(posedge clk) begin
    if (rst)     m_val <= 32'h0;
    else if (en) m_val <= pick(int'(alu1_sel), rs1_d, pc);
    m_valid <= 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison, half a cycle after the edge.
  always @(negedge clk) begin
    if (m_valid && !done) chk("model", alu_in1, m_val);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] rs_vals [5] = '{32'd10, 32'd3, 32'hFFFF_FFFC, 32'd4, 32'hFFFF_FFF0};
  logic [31:0] pc_vals [6] = '{32'd0, 32'd1, 32'd2, 32'd10, 32'hFFFF_FFF0, 32'hFFFF_FFFC};

  initial begin
    rst = 1'b1; en = 1'b1; alu1_sel = '0; rs1_d = 32'd10; pc = 32'd2;

    // Reset has priority over en and data.
    tick; chk("reset_c0", alu_in1, 32'h0);
    tick; chk("reset_c1", alu_in1, 32'h0);
    rst = 1'b0;
    tick; chk("reset_release", alu_in1, 32'd10);

    alu1_sel = '0;
    for (int i = 0; i < 5; i++) begin
      rs1_d = rs_vals[i];
      pc    = $urandom;
      tick; chk("rs_path", alu_in1, rs_vals[i]);
    end

    alu1_sel = 1;
    for (int i = 0; i < 6; i++) begin
      pc    = pc_vals[i];
      rs1_d = (i == 2) ? 'x : $urandom;
      tick; chk("pc_path", alu_in1, pc_vals[i]);
    end

    rs1_d = 32'h55; pc = 32'hAA;
    alu1_sel = 0; tick; chk("switch_rs",  alu_in1, 32'h55);
    alu1_sel = 1; tick; chk("switch_pc",  alu_in1, 32'hAA);
    alu1_sel = 0; tick; chk("switch_rs2", alu_in1, 32'h55);

    rs1_d = 32'd3; tick; chk("stall_load", alu_in1, 32'd3);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rs1_d = $urandom; pc = $urandom; alu1_sel = ALU1_SEL_W'(i);
      tick; chk("stall_hold", alu_in1, 32'd3);
    end
    en = 1'b1; alu1_sel = 0; rs1_d = 32'h77;
    tick; chk("stall_resume", alu_in1, 32'h77);

    rst = 1'b1; en = 1'b0;
    tick; chk("reset_during_stall", alu_in1, 32'h0);
    rst = 1'b0; rs1_d = 32'd9;
    tick; chk("release_en_low", alu_in1, 32'h0);
    tick; chk("release_en_low2", alu_in1, 32'h0);
    en = 1'b1;
    tick; chk("first_en_after_reset", alu_in1, 32'd9);

`ifdef ALU1_ZERO_SEL_EN
    rs1_d = 32'd7; pc = 32'd9;
    alu1_sel = 2'b10; tick; chk("sel_zero",     alu_in1, 32'h0);
    alu1_sel = 2'b11; tick; chk("sel_reserved", alu_in1, 32'd7);
    alu1_sel = 2'b01; tick; chk("sel_pc_wide",  alu_in1, 32'd9);
`endif

    @(negedge clk);
    done = 1'b1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
